weight_fetch: RTL and testbench

Write-side feeder for the weight FIFO. On a start pulse it reads one weight tile, DIM rows of DIM elements each, from the synchronous weight SRAM. It pushes exactly DIM rows into the weight FIFO through that FIFO's en/weightIn port, zero-padding any missing rows. It sits between the weight memory and weightFifo, accepts a downstream stall, and signals completion with a one-cycle done pulse.

---
 rtl/weight_fetch.sv | 85 ++++++++
 tb/tb_weight_fetch.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/weight_fetch.sv
// weight_fetch: streams one DIM x DIM weight tile from SRAM into the weight FIFO, zero-padding missing rows
module weight_fetch #(
    parameter int WIDTH      = 8,
    parameter int DIM        = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] baseAddr,
    input  logic [ADDR_WIDTH-1:0] numRows,
    input  logic                  stall,
    output logic                  memEn,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [WIDTH*DIM-1:0]  memData,
    output logic                  fifoEn,
    output logic [WIDTH*DIM-1:0]  fifoData,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = $clog2(DIM + 1);
    localparam int RW = WIDTH * DIM;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base, addr_q;
    logic [CW-1:0]         nrows, row;
    logic                  pend, pend_zero, held;
    logic [RW-1:0]         hold, ret_data;
    logic                  issue, real_row, push;

    // At most one slot is in flight, so a returning row and a held row never coexist.
    always_comb begin
        issue    = state == FETCH && !stall;
        real_row = row < nrows;
        memEn    = issue && real_row;
        memAddr  = memEn ? base + ADDR_WIDTH'(row) : addr_q;
        ret_data = pend_zero ? '0 : memData;
        push     = !stall && (held || pend);
        fifoEn   = push;
        fifoData = !push ? '0 : held ? hold : ret_data;
        busy     = state != IDLE;
        done     = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            base      <= '0;
            addr_q    <= '0;
            nrows     <= '0;
            row       <= '0;
            pend      <= 1'b0;
            pend_zero <= 1'b0;
            held      <= 1'b0;
            hold      <= '0;
        end else begin
            addr_q    <= memAddr;
            pend      <= issue;
            pend_zero <= issue && !real_row;
            if (pend && stall) begin
                held <= 1'b1;
                hold <= ret_data;
            end else if (held && !stall) begin
                held <= 1'b0;
                hold <= '0;
            end
            case (state)
                IDLE: if (start) begin
                    base  <= baseAddr;
                    nrows <= (numRows > ADDR_WIDTH'(DIM)) ? CW'(DIM) : numRows[CW-1:0];
                    row   <= '0;
                    state <= FETCH;
                end
                FETCH: if (issue) begin
                    row <= row + CW'(1);
                    if (row == CW'(DIM - 1)) state <= DRAIN;
                end
                DRAIN: if (push) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_fetch.sv
// tb_weight_fetch: scoreboarded directed test of weight_fetch (DIM=4, WIDTH=8)
module tb_weight_fetch;
    logic        clk = 0, reset = 1, start = 0, stall = 0;
    logic [7:0]  baseAddr = 0, numRows = 0, memAddr;
    logic [31:0] memData = 0, fifoData;
    logic        memEn, fifoEn, busy, done;

    typedef struct {logic [31:0] v; int c;} ent_t;
    ent_t pq[$], mq[$];
    ent_t pe, me;
    int errs = 0, checks = 0, cyc = -2;

    weight_fetch #(.WIDTH(8), .DIM(4), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr), .numRows(numRows),
        .stall(stall), .memEn(memEn), .memAddr(memAddr), .memData(memData),
        .fifoEn(fifoEn), .fifoData(fifoData), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sram(input logic [7:0] a);
        logic [7:0] k;
        k = {a[5:0], 2'b00};
        return {k + 8'd3, k + 8'd2, k + 8'd1, k};
    endfunction

    // Garbage on unread cycles exposes a missing zero-row mask.
    always @(posedge clk) memData <= memEn ? sram(memAddr) : 32'hDEADBEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic ep(input logic [31:0] v, input int c);
        pq.push_back('{v, c});
    endtask

    task automatic em(input logic [31:0] a, input int c);
        mq.push_back('{a, c});
    endtask

    always @(negedge clk) if (cyc > -2) begin
        if (fifoEn) begin
            if (pq.size() == 0) chk("push_unexpected", 32'(fifoEn), 32'd0);
            else begin
                pe = pq.pop_front();
                chk("push_data", fifoData, pe.v);
                chk("push_cycle", 32'(cyc), 32'(pe.c));
            end
        end else if (fifoData !== 32'd0) chk("data_idle_zero", fifoData, 32'd0);
        if (memEn) begin
            if (mq.size() == 0) chk("mem_unexpected", 32'(memEn), 32'd0);
            else begin
                me = mq.pop_front();
                chk("mem_addr", 32'(memAddr), me.v);
                chk("mem_cycle", 32'(cyc), 32'(me.c));
            end
        end
    end

    task automatic run(input logic [7:0] b, input logic [7:0] n, input logic [15:0] sm,
                       input int rst_c, input int st2_c, input int done_c, input int n_mem);
        int dn, dc, mn, last;
        dn = 0; dc = 0; mn = 0;
        last = (done_c > 0 ? done_c : 6) + 2;
        @(posedge clk); #1;
        baseAddr = b; numRows = n; start = 1; cyc = 0;
        @(posedge clk); #1;
        start = 0;
        for (int c = 1; c <= last; c++) begin
            cyc = c; stall = sm[c]; reset = (c == rst_c); start = (c == st2_c);
            if (start) begin baseAddr = 8'h40; numRows = 8'd1; end
            @(negedge clk);
            if (done) begin dn++; dc = c; end
            if (memEn) mn++;
            if (rst_c == 0 || c != rst_c + 1)
                chk("busy", 32'(busy), 32'(rst_c > 0 ? c <= rst_c : c <= done_c));
            @(posedge clk); #1;
        end
        stall = 0; start = 0; reset = 0; cyc = -1;
        chk("done_count", 32'(dn), 32'(done_c > 0));
        if (done_c > 0) chk("done_cycle", 32'(dc), 32'(done_c));
        chk("mem_count", 32'(mn), 32'(n_mem));
        chk("push_left", 32'(pq.size()), 32'd0);
        chk("mem_left", 32'(mq.size()), 32'd0);
        pq.delete(); mq.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_memEn", 32'(memEn), 0); chk("rst_memAddr", 32'(memAddr), 0);
        chk("rst_fifoEn", 32'(fifoEn), 0); chk("rst_fifoData", fifoData, 0);
        chk("rst_busy", 32'(busy), 0); chk("rst_done", 32'(done), 0);
        start = 1;
        @(posedge clk); #1;
        chk("rst_beats_start", 32'(busy), 0);
        reset = 0; start = 0; cyc = -1;

        // 1: plain four-row tile
        em(0, 1); em(1, 2); em(2, 3); em(3, 4);
        ep(32'h03020100, 2); ep(32'h07060504, 3); ep(32'h0B0A0908, 4); ep(32'h0F0E0D0C, 5);
        run(8'h00, 8'd4, 16'h0000, 0, 0, 6, 4);
        // 2: two rows, zero padded
        em(0, 1); em(1, 2);
        ep(32'h03020100, 2); ep(32'h07060504, 3); ep(0, 4); ep(0, 5);
        run(8'h00, 8'd2, 16'h0000, 0, 0, 6, 2);
        // 2b: no rows at all
        ep(0, 2); ep(0, 3); ep(0, 4); ep(0, 5);
        run(8'h00, 8'd0, 16'h0000, 0, 0, 6, 0);
        // 3: single stall cycle goes through the hold register
        em(0, 1); em(1, 2); em(2, 4); em(3, 5);
        ep(32'h03020100, 2); ep(32'h07060504, 4); ep(32'h0B0A0908, 5); ep(32'h0F0E0D0C, 6);
        run(8'h00, 8'd4, 16'h0008, 0, 0, 7, 4);
        // 3b: long stall, cycles 3-6
        em(0, 1); em(1, 2); em(2, 7); em(3, 8);
        ep(32'h03020100, 2); ep(32'h07060504, 7); ep(32'h0B0A0908, 8); ep(32'h0F0E0D0C, 9);
        run(8'h00, 8'd4, 16'h0078, 0, 0, 10, 4);
        // 4: address wrap
        em(8'hFE, 1); em(8'hFF, 2); em(8'h00, 3); em(8'h01, 4);
        ep(32'hFBFAF9F8, 2); ep(32'hFFFEFDFC, 3); ep(32'h03020100, 4); ep(32'h07060504, 5);
        run(8'hFE, 8'd4, 16'h0000, 0, 0, 6, 4);
        // 5: reset mid-fetch, then a fresh normal fetch
        em(0, 1); em(1, 2);
        ep(32'h03020100, 2);
        run(8'h00, 8'd4, 16'h0000, 2, 0, 0, 2);
        em(0, 1); em(1, 2); em(2, 3); em(3, 4);
        ep(32'h03020100, 2); ep(32'h07060504, 3); ep(32'h0B0A0908, 4); ep(32'h0F0E0D0C, 5);
        run(8'h00, 8'd4, 16'h0000, 0, 0, 6, 4);
        // 6: clamp plus ignored restart
        em(4, 1); em(5, 2); em(6, 3); em(7, 4);
        ep(32'h13121110, 2); ep(32'h17161514, 3); ep(32'h1B1A1918, 4); ep(32'h1F1E1D1C, 5);
        run(8'h04, 8'd7, 16'h0000, 0, 2, 6, 4);
        // stall during DONE does not delay done
        em(0, 1); em(1, 2); em(2, 3); em(3, 4);
        ep(32'h03020100, 2); ep(32'h07060504, 3); ep(32'h0B0A0908, 4); ep(32'h0F0E0D0C, 5);
        run(8'h00, 8'd4, 16'h0040, 0, 0, 6, 4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
